// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver: mid-bit sampling off a clock-enable baud tick, valid/ready byte output.
// Optional even-parity bit and parity_err port when UART_RX_PARITY_EN is defined.
module uart_rx_os #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW     = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
  localparam logic [SCW-1:0] SC_HALF  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
  } state_t;

  state_t         state, state_nxt;
  logic           rx_meta, rxs;
  logic [CW-1:0]  cnt;
  logic           tick;
  logic [SCW-1:0] sc;
  logic [2:0]     idx;
  logic [7:0]     shift;
  logic           par_bad;
  logic           at_last, bit_take, stop_take, byte_ok, stop_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Free-running divider; never re-phased by the line.
  always_ff @(posedge clk) begin
    if (rst || cnt == CNT_LAST) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end
  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (tick && !rxs) state_nxt = S_START;
      S_START:   if (tick && sc == SC_HALF) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:
        if (tick && sc == SC_LAST && idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      S_PARITY:  if (tick && sc == SC_LAST) state_nxt = S_STOP;
      S_STOP:    if (tick && sc == SC_LAST) state_nxt = rxs ? S_IDLE : S_WAIT_HI;
      // A held-low line (break) must not be read as a stream of 0x00 bytes.
      S_WAIT_HI: if (tick && rxs) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    at_last   = tick && (sc == SC_LAST);
    bit_take  = (state == S_DATA) && at_last;
    stop_take = (state == S_STOP) && at_last;
    byte_ok   = stop_take && rxs && !par_bad;
    stop_bad  = stop_take && !rxs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc    <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      if (state == S_IDLE || state_nxt != state || bit_take) sc <= '0;
      else if (tick)                                         sc <= sc + 1'b1;
      if (state == S_START) idx <= '0;
      else if (bit_take)    idx <= idx + 1'b1;
      if (bit_take) shift <= {rxs, shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst || state == S_START)         par_bad <= 1'b0;
    else if (state == S_PARITY && at_last) par_bad <= rxs ^ (^shift);
  end

  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= stop_take && par_bad;
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= byte_ok && dout_valid && !dout_ready;
      if (byte_ok && (!dout_valid || dout_ready)) begin
        dout       <= shift;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
